// File: rtl/irigb_encoder_if.sv
// Host-side bundle for irigb_encoder: run control, BCD time inputs and the
// registered IRIG-B outputs. state_dbg mirrors the encoder FSM (0=IDLE, 1=RUN).
interface irigb_encoder_if;
  // Handshake: enable is a level, pps is rising-edge significant, time_load is a
  // one-cycle strobe that is always accepted (no ready); all outputs are registered.
  logic       enable;
  logic       pps;
  logic       time_load;
  logic [6:0] sec_bcd;
  logic [6:0] min_bcd;
  logic [5:0] hour_bcd;
  logic [9:0] day_bcd;
  logic [7:0] year_bcd;
  logic       irigb_out;
  logic       frame_start;
  logic       running;
  logic       state_dbg;

  modport master (
    output enable, pps, time_load, sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd,
    input  irigb_out, frame_start, running, state_dbg
  );

  modport slave (
    input  enable, pps, time_load, sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd,
    output irigb_out, frame_start, running, state_dbg
  );
endinterface

// File: rtl/irigb_encoder.sv
// IRIG-B (B00x) DC-level encoder aligned to 1 PPS, with shadow/frame time registers.
// Optional IRIGB_SBS_EN adds straight-binary seconds-of-day in bits 80-88 / 90-97.
module irigb_encoder #(
  parameter int CLKFREQ = 100_000_000
) (
  input logic            clk,
  input logic            rst,
  irigb_encoder_if.slave bus
);
  localparam int TICKS  = CLKFREQ / 1000;
  localparam int TICK_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICKS - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  typedef struct packed {
    logic [7:0] year;
    logic [9:0] day;
    logic [5:0] hour;
    logic [6:0] min;
    logic [6:0] sec;
  } time_t;

  state_t            state, state_n;
  logic [TICK_W-1:0] tick, tick_n;
  logic [3:0]        ms, ms_n;
  logic [6:0]        bit_idx, bit_n;
  logic              pps_d;
  logic              pps_rise;
  logic              frame_go;
  time_t             in_time, shadow, frame_reg;
  logic [99:0]       stream;
  logic              is_marker;
  logic [3:0]        hi_ms;
  logic              level;

  assign pps_rise      = bus.pps & ~pps_d;
  assign in_time       = {bus.year_bcd, bus.day_bcd, bus.hour_bcd, bus.min_bcd, bus.sec_bcd};
  assign bus.state_dbg = (state == RUN);

  // Next-state and counter advance; frame_go marks the edge where a frame begins.
  always_comb begin
    state_n  = state;
    tick_n   = tick;
    ms_n     = ms;
    bit_n    = bit_idx;
    frame_go = 1'b0;
    if (!bus.enable) begin
      state_n = IDLE;
      tick_n  = '0;
      ms_n    = '0;
      bit_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          tick_n = '0;
          ms_n   = '0;
          bit_n  = '0;
          if (pps_rise) begin
            state_n  = RUN;
            frame_go = 1'b1;
          end
        end
        RUN: begin
          if (pps_rise) begin
            tick_n   = '0;
            ms_n     = '0;
            bit_n    = '0;
            frame_go = 1'b1;
          end else if (tick == TICK_MAX) begin
            tick_n = '0;
            if (ms == 4'd9) begin
              ms_n = '0;
              if (bit_idx == 7'd99) begin
                bit_n    = '0;
                frame_go = 1'b1;
              end else begin
                bit_n = bit_idx + 7'd1;
              end
            end else begin
              ms_n = ms + 4'd1;
            end
          end else begin
            tick_n = tick + TICK_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

`ifdef IRIGB_SBS_EN
  logic [16:0] sbs;
  assign sbs = (17'(frame_reg.hour[5:4]) * 17'd10 + 17'(frame_reg.hour[3:0])) * 17'd3600
             + (17'(frame_reg.min[6:4])  * 17'd10 + 17'(frame_reg.min[3:0]))  * 17'd60
             +  17'(frame_reg.sec[6:4])  * 17'd10 + 17'(frame_reg.sec[3:0]);
`endif

  always_comb begin
    stream        = '0;
    stream[4:1]   = frame_reg.sec[3:0];
    stream[8:6]   = frame_reg.sec[6:4];
    stream[13:10] = frame_reg.min[3:0];
    stream[17:15] = frame_reg.min[6:4];
    stream[23:20] = frame_reg.hour[3:0];
    stream[26:25] = frame_reg.hour[5:4];
    stream[33:30] = frame_reg.day[3:0];
    stream[38:35] = frame_reg.day[7:4];
    stream[41:40] = frame_reg.day[9:8];
    stream[53:50] = frame_reg.year[3:0];
    stream[58:55] = frame_reg.year[7:4];
`ifdef IRIGB_SBS_EN
    stream[88:80] = sbs[8:0];
    stream[97:90] = sbs[16:9];
`endif
  end

  // High time in ms for the current bit: marker 8, one 5, zero 2.
  always_comb begin
    is_marker = (bit_idx == 7'd0);
    for (int k = 9; k < 100; k += 10) begin
      if (bit_idx == 7'(k)) is_marker = 1'b1;
    end
    if (is_marker)            hi_ms = 4'd8;
    else if (stream[bit_idx]) hi_ms = 4'd5;
    else                      hi_ms = 4'd2;
  end

  assign level = (state == RUN) && (ms < hi_ms);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      tick            <= '0;
      ms              <= '0;
      bit_idx         <= '0;
      pps_d           <= 1'b0;
      shadow          <= '0;
      frame_reg       <= '0;
      bus.irigb_out   <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.running     <= 1'b0;
    end else begin
      state   <= state_n;
      tick    <= tick_n;
      ms      <= ms_n;
      bit_idx <= bit_n;
      pps_d   <= bus.pps;
      if (bus.time_load) shadow <= in_time;
      // A load on the frame-start edge bypasses the shadow into this frame.
      if (frame_go) frame_reg <= bus.time_load ? in_time : shadow;
      bus.irigb_out   <= bus.enable && level;
      bus.frame_start <= bus.enable && (state == RUN) && (bit_idx == 7'd0)
                         && (ms == 4'd0) && (tick == '0);
      bus.running     <= bus.enable && (state == RUN);
    end
  end
endmodule

// File: doc/irigb_encoder.md
# irigb_encoder

Generates a DC-level-shift IRIG-B (B00x) time-code stream from a latched BCD time of day, aligned to a 1 PPS input. It is the transmit-side counterpart to the IRIG-B decoder and sits in the same clock domain. It is used as a local time source for the decoder loopback and for downstream slaves. It also produces a per-frame start strobe.

## Interface
- `CLKFREQ`, 100_000_000, input clock frequency in Hz. It must be a multiple of 1000.
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous reset, active-high
- `enable`  in  1  encoder run enable, level-sensitive
- `pps`  in  1  1 PPS reference, synchronous to `clk`, rising edge significant
- `time_load`  in  1  single-cycle strobe that latches the time inputs into the shadow register
- `sec_bcd`  in  7  seconds: [3:0] units, [6:4] tens
- `min_bcd`  in  7  minutes: [3:0] units, [6:4] tens
- `hour_bcd`  in  6  hours: [3:0] units, [5:4] tens
- `day_bcd`  in  10  day of year: [3:0] units, [7:4] tens, [9:8] hundreds
- `year_bcd`  in  8  year: [3:0] units, [7:4] tens
- `irigb_out`  out  1  IRIG-B DC level output, registered
- `frame_start`  out  1  one-cycle pulse at the first clock of bit 0
- `running`  out  1  high while the encoder is in the RUN state

## Operation
- 1 ms tick: a counter runs from 0 to CLKFREQ/1000-1. Its wrap advances the ms-in-bit counter (0–9). The ms wrap advances the bit index (0–99). The bit-index wrap at 99 starts the next frame (free-run).
- Bit widths, measured as `irigb_out` high time from the start of the bit:
  - '0' = 2 ms
  - '1' = 5 ms
  - marker P = 8 ms
  - The output is low for the rest of the 10 ms bit.
- Markers are at bits 0 (Pr), 9, 19, 29, 39, 49, 59, 69, 79, 89, 99.
- Field placement (LSB first within each BCD digit):
  - seconds units 1–4, tens 6–8
  - minutes units 10–13, tens 15–17
  - hours units 20–23, tens 25–26
  - day units 30–33, tens 35–38, hundreds 40–41
  - year units 50–53, tens 55–58
  - All other non-marker bits from 0 to 79 are '0'.
- `time_load` copies the inputs into the shadow register. At each frame start the shadow register is copied to the frame register, which drives encoding for that whole frame.
- FSM:
  - IDLE: output low. Leave IDLE on the first `pps` rising edge while `enable`=1, and go to RUN.
  - RUN: frames run back to back. Any `pps` rising edge resets the tick, ms and bit counters to 0 and starts a new frame, aborting a frame in progress.
  - If `enable`=0 in any state, go to IDLE on the next clock, drive `irigb_out` low and clear the counters.
- Boundary rules:
  - If `time_load` coincides with a frame start, the new input values are used for that frame (bypass).
  - Field values are not range-checked. They are encoded exactly as presented.
  - `rst` asserted mid-frame forces everything to its reset state immediately.

## Timing
- Reset values: `irigb_out`=0, `frame_start`=0, `running`=0. All counters, the shadow register and the frame register are 0. The FSM is in IDLE.
- Latency from a `pps` edge: `pps` is sampled high at clock edge N (with the sampled value low at N-1). At edge N+1, `irigb_out`=1, `frame_start`=1 and `running`=1.
- Output transitions occur on tick-counter wrap boundaries: exactly W×(CLKFREQ/1000) clocks high per bit.
- Bit period is 10×CLKFREQ/1000 clocks. The free-run frame period is 1000×CLKFREQ/1000 clocks.

## Configuration
- `IRIGB_SBS_EN` defined: straight binary seconds-of-day (hour×3600 + min×60 + sec, 17 bits, computed from the frame register) is encoded LSB first.
  - SBS bits 0–8 go to stream bits 80–88.
  - SBS bits 9–16 go to stream bits 90–97.
  - Stream bit 98 is '0'.
- `IRIGB_SBS_EN` undefined: stream bits 80–88 and 90–98 are '0'. No SBS arithmetic is synthesized.

## Test plan
All scenarios use CLKFREQ=10_000, so 1 ms = 10 clk, 1 bit = 100 clk and 1 frame = 10_000 clk.
- Reset then idle: `rst` pulse, `enable`=1, no `pps` -> `irigb_out`=0 and `running`=0 for 20_000 clk.
- Basic frame: load 23:59:58, day 366, year 24, then `pps` -> marker high times are 80 clk at bits 0 and 9. Decoded fields match the loaded values, bit 5 is '0', and `frame_start` is 1 cycle wide.
- Free-run: no further `pps` -> a second `frame_start` occurs exactly 10_000 clk after the first, carrying the same time unless `time_load` occurred.
- PPS resync: `pps` at clk 4_321 into a frame -> `irigb_out` rises 1 clk later, `frame_start` pulses, and the bit index restarts at 0.
- Load/frame collision: `time_load` with sec=0x15 on the same cycle as the frame start -> that frame encodes seconds 15.
- SBS (`IRIGB_SBS_EN`): time 12:34:56 -> bits 80–97 carry 45296 = 0x0B0F0 LSB first. With the macro undefined, those bits are all '0' (2 ms pulses).
